lvl_request_queue: RTL and testbench
====================================

Name: lvl_request_queue

Overview:
- Registered, parametrised FIFO of pending elevator floor requests.
- Sits between the call-button encoder (upstream) and the car motion controller (downstream).
- Accepts a pressed level only if it is in range, not already pending, and there is room.
- Exposes the oldest request as head; controller pops it on arrival. Generalises the combinational add-new-level check into a stateful, depth/width-parametrised queue with status and reject reporting.

Parameters:
- LVL_W, 2: bits per level code.
- DEPTH, 4: number of queue entries, ≥2.
- NUM_LVL, 4: valid levels are 0..NUM_LVL-1; NUM_LVL ≤ 2**LVL_W.

Ports:
- clk  in  1  rising-edge clock.
- rst_n  in  1  reset; one clock; reset is asynchronous and active-low.
- pressed_en  in  1  push request strobe.
- pressed_lvl  in  LVL_W  level being requested.
- pop_en  in  1  car arrived at head level; remove head.
- head_lvl  out  LVL_W  oldest pending level (entry 0).
- head_valid  out  1  queue non-empty.
- count  out  $clog2(DEPTH+1)  number of valid entries.
- full  out  1  count==DEPTH.
- queue_flat  out  DEPTH*LVL_W  entries; entry i at bits [i*LVL_W +: LVL_W], entry 0 = head.
- valid_flat  out  DEPTH  per-entry valid bits.
- rej_dup  out  1  registered pulse: last push dropped as duplicate.
- rej_full  out  1  registered pulse: last push dropped, no room.
- rej_range  out  1  registered pulse: last push dropped, level ≥ NUM_LVL.

Behaviour:
- Reset: all entries 0, valid_flat=0, count=0, head_valid=0, head_lvl=0, full=0, all rej_* = 0.
- Storage is a shift queue.
  - Entry 0 is always the head.
  - Valid entries are contiguous from 0.
  - Tail index = count.
- All outputs except head_lvl/head_valid/full are registered state. head_*/full decode combinationally from registers (no input-to-output paths).
- Push latency 1 cycle: an accepted push is visible in queue_flat/count on the next cycle.
- pop_en with count==0 is ignored; no error is raised.
- Pop shifts entries i+1→i, clears the vacated top valid bit, and sets count -= 1.
- Push evaluation, in priority order (exactly one rej_* may pulse per cycle):
  1. pressed_lvl ≥ NUM_LVL → rej_range.
  2. pressed_lvl matches any currently valid entry, including a head being popped this cycle → rej_dup. Car is at that floor.
  3. count==DEPTH and no pop this cycle → rej_full.
  4. Otherwise accept: write at index count (or count-1 if popping the same cycle).
- Simultaneous accepted push + pop:
  - Shift, then write new entry at count-1; count unchanged.
  - Full + pop + push is legal and stays full.
- Push and pop with count==1, push accepted: result is count=1, head=new level.
- rej_* are 0 in any cycle without pressed_en.
- Count never exceeds DEPTH or underflows. Assertions are required on both.
- Reset asserted mid-operation clears everything asynchronously. On deassertion, the first edge behaves as from empty.

Optional Feature:
- Macro: LVL_QUEUE_CANCEL_EN.
- With the macro defined:
  - Ports added: cancel_en (in 1) and cancel_lvl (in LVL_W).
  - The matching valid entry (at most one exists) is removed, later entries shift down one, and count -= 1. No match is a silent no-op.
  - Same-cycle ordering is pop, then cancel, then push. Duplicate and full checks for the push use the post-pop, post-cancel queue.
  - Cancel of the head coincident with pop of the head removes one entry only.
- Without the macro: no cancel ports; behaviour exactly as above.

Decomposition:
- Package elevator_pkg holds:
  - LVL_W, DEPTH, NUM_LVL defaults.
  - CNT_W = $clog2(DEPTH+1).
  - typedef lvl_t (logic [LVL_W-1:0]).
  - typedef rej_e {REJ_NONE, REJ_RANGE, REJ_DUP, REJ_FULL}.
- One sub-module, lvl_in_queue_match (combinational): lvl, entries, valid → DEPTH-bit hit vector plus any_hit. It is reused for the duplicate check and for the cancel index.

Test Plan:
- Reset, then push 2,0,3 → count=3, queue_flat entries [2,0,3], head_lvl=2, no rej_*.
- Queue [2,0,3], push 0 → rej_dup=1 next cycle, count stays 3.
- Fill DEPTH=4 with [1,2,3,0], push 1 → rej_dup. Push with NUM_LVL=3 and level 3 → rej_range. A full queue with an in-range new level is unreachable at DEPTH=NUM_LVL, so verify rej_full with DEPTH=2, NUM_LVL=4: [0,1] + push 2 → rej_full.
- DEPTH=2, [0,1], pop + push 2 same cycle → [1,2], count=2, full=1. Pop + push 0 on head 0 → rej_dup, result [1].
- Pop on empty ×3 → count=0, head_valid=0, no X. rst_n low mid-stream with count=3 → all outputs 0 immediately, before the next clk edge.
- LVL_QUEUE_CANCEL_EN: [2,0,3], cancel 0 → [2,3], count=2. Cancel 2 + pop + push 2 same cycle → [3,2].

Source files
------------

// File: rtl/elevator_pkg.sv
// Shared types and default sizing for the elevator request path.
// Consumed by lvl_request_queue and lvl_in_queue_match.
package elevator_pkg;

  localparam int LVL_W   = 2;
  localparam int DEPTH   = 4;
  localparam int NUM_LVL = 4;
  localparam int CNT_W   = $clog2(DEPTH + 1);

  typedef logic [LVL_W-1:0] lvl_t;

  typedef enum logic [1:0] {
    REJ_NONE,
    REJ_RANGE,
    REJ_DUP,
    REJ_FULL
  } rej_e;

endpackage

// File: rtl/lvl_in_queue_match.sv
// Combinational level lookup: flags every valid queue entry equal to lvl.
// Used for the push duplicate check and for locating a cancelled level.
module lvl_in_queue_match #(
  parameter int LVL_W = 2,
  parameter int DEPTH = 4
) (
  input  logic [LVL_W-1:0]       lvl,
  input  logic [DEPTH*LVL_W-1:0] entries,
  input  logic [DEPTH-1:0]       valid,
  output logic [DEPTH-1:0]       hit,
  output logic                   any_hit
);

  always_comb begin
    hit = '0;
    for (int i = 0; i < DEPTH; i++) begin
      hit[i] = valid[i] && (entries[i*LVL_W +: LVL_W] == lvl);
    end
  end

  assign any_hit = |hit;

endmodule

// File: rtl/lvl_request_queue.sv
// Shift-register FIFO of pending floor requests; entry 0 is always the head.
// Optional LVL_QUEUE_CANCEL_EN adds cancel_en/cancel_lvl to withdraw a pending level.
module lvl_request_queue #(
  parameter int LVL_W   = elevator_pkg::LVL_W,
  parameter int DEPTH   = elevator_pkg::DEPTH,
  parameter int NUM_LVL = elevator_pkg::NUM_LVL
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic                       pressed_en,
  input  logic [LVL_W-1:0]           pressed_lvl,
  input  logic                       pop_en,
`ifdef LVL_QUEUE_CANCEL_EN
  input  logic                       cancel_en,
  input  logic [LVL_W-1:0]           cancel_lvl,
`endif
  output logic [LVL_W-1:0]           head_lvl,
  output logic                       head_valid,
  output logic [$clog2(DEPTH+1)-1:0] count,
  output logic                       full,
  output logic [DEPTH*LVL_W-1:0]     queue_flat,
  output logic [DEPTH-1:0]           valid_flat,
  output logic                       rej_dup,
  output logic                       rej_full,
  output logic                       rej_range
);

  localparam int CNT_W = $clog2(DEPTH + 1);

  import elevator_pkg::*;

  logic [LVL_W-1:0]       q_q [DEPTH];
  logic [DEPTH-1:0]       v_q;
  logic [CNT_W-1:0]       count_q;
  logic                   rej_dup_q, rej_full_q, rej_range_q;

  logic [LVL_W-1:0]       q_pop [DEPTH];
  logic [LVL_W-1:0]       q_can [DEPTH];
  logic [LVL_W-1:0]       q_d   [DEPTH];
  logic [DEPTH-1:0]       v_pop, v_can, v_d;
  logic [CNT_W-1:0]       c_pop, c_can, count_d;
  logic [DEPTH*LVL_W-1:0] q_cur_flat, q_chk_flat;
  logic [DEPTH-1:0]       v_chk;
  logic [DEPTH-1:0]       dup_hit;
  logic                   dup_any;
  logic                   do_pop, in_range, push_ok;
  rej_e                   rej_d;

  always_comb begin
    q_cur_flat = '0;
    for (int i = 0; i < DEPTH; i++) begin
      q_cur_flat[i*LVL_W +: LVL_W] = q_q[i];
    end
  end

  // Stage 1: pop shifts everything down and clears the vacated top slot.
  assign do_pop = pop_en && (count_q != '0);

  always_comb begin
    v_pop = '0;
    for (int i = 0; i < DEPTH-1; i++) begin
      q_pop[i] = do_pop ? q_q[i+1] : q_q[i];
      v_pop[i] = do_pop ? v_q[i+1] : v_q[i];
    end
    q_pop[DEPTH-1] = do_pop ? '0 : q_q[DEPTH-1];
    v_pop[DEPTH-1] = do_pop ? 1'b0 : v_q[DEPTH-1];
    c_pop = count_q - CNT_W'(do_pop);
  end

`ifdef LVL_QUEUE_CANCEL_EN
  logic [DEPTH*LVL_W-1:0] q_pop_flat;
  logic [DEPTH-1:0]       can_hit, can_sh;
  logic                   can_any;

  always_comb begin
    q_pop_flat = '0;
    for (int i = 0; i < DEPTH; i++) begin
      q_pop_flat[i*LVL_W +: LVL_W] = q_pop[i];
    end
  end

  lvl_in_queue_match #(.LVL_W(LVL_W), .DEPTH(DEPTH)) u_cancel_match (
    .lvl     (cancel_lvl),
    .entries (q_pop_flat),
    .valid   (v_pop),
    .hit     (can_hit),
    .any_hit (can_any)
  );

  // Stage 2: the matched entry and everything above it shift down one.
  always_comb begin
    logic shift;
    shift  = 1'b0;
    can_sh = '0;
    for (int i = 0; i < DEPTH; i++) begin
      shift     = shift | (cancel_en & can_hit[i]);
      can_sh[i] = shift;
    end
    v_can = '0;
    for (int i = 0; i < DEPTH-1; i++) begin
      q_can[i] = can_sh[i] ? q_pop[i+1] : q_pop[i];
      v_can[i] = can_sh[i] ? v_pop[i+1] : v_pop[i];
    end
    q_can[DEPTH-1] = can_sh[DEPTH-1] ? '0 : q_pop[DEPTH-1];
    v_can[DEPTH-1] = can_sh[DEPTH-1] ? 1'b0 : v_pop[DEPTH-1];
    c_can = c_pop - CNT_W'(cancel_en & can_any);
  end

  // Push sees the queue after pop and cancel have been applied.
  always_comb begin
    q_chk_flat = '0;
    for (int i = 0; i < DEPTH; i++) begin
      q_chk_flat[i*LVL_W +: LVL_W] = q_can[i];
    end
    v_chk = v_can;
  end
`else
  always_comb begin
    for (int i = 0; i < DEPTH; i++) begin
      q_can[i] = q_pop[i];
    end
    v_can = v_pop;
    c_can = c_pop;
  end

  // A head being popped still counts as pending: the car is at that floor.
  assign q_chk_flat = q_cur_flat;
  assign v_chk      = v_q;
`endif

  lvl_in_queue_match #(.LVL_W(LVL_W), .DEPTH(DEPTH)) u_dup_match (
    .lvl     (pressed_lvl),
    .entries (q_chk_flat),
    .valid   (v_chk),
    .hit     (dup_hit),
    .any_hit (dup_any)
  );

  assign in_range = 32'(pressed_lvl) < 32'(NUM_LVL);

  // Stage 3: push at the tail of the already-shifted queue.
  always_comb begin
    rej_d = REJ_NONE;
    if (pressed_en) begin
      if (!in_range) begin
        rej_d = REJ_RANGE;
      end else if (dup_any) begin
        rej_d = REJ_DUP;
      end else if (c_can == CNT_W'(DEPTH)) begin
        rej_d = REJ_FULL;
      end
    end
    push_ok = pressed_en && (rej_d == REJ_NONE);
    v_d = '0;
    for (int i = 0; i < DEPTH; i++) begin
      if (push_ok && (CNT_W'(i) == c_can)) begin
        q_d[i] = pressed_lvl;
        v_d[i] = 1'b1;
      end else begin
        q_d[i] = q_can[i];
        v_d[i] = v_can[i];
      end
    end
    count_d = c_can + CNT_W'(push_ok);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < DEPTH; i++) begin
        q_q[i] <= '0;
      end
      v_q         <= '0;
      count_q     <= '0;
      rej_dup_q   <= 1'b0;
      rej_full_q  <= 1'b0;
      rej_range_q <= 1'b0;
    end else begin
      for (int i = 0; i < DEPTH; i++) begin
        q_q[i] <= q_d[i];
      end
      v_q         <= v_d;
      count_q     <= count_d;
      rej_dup_q   <= (rej_d == REJ_DUP);
      rej_full_q  <= (rej_d == REJ_FULL);
      rej_range_q <= (rej_d == REJ_RANGE);
    end
  end

`ifndef SYNTHESIS
  always @(posedge clk) begin
    if (rst_n) begin
      assert (count_d <= CNT_W'(DEPTH));
      assert (c_pop <= count_q);
      assert (c_can <= c_pop);
    end
  end
`endif

  assign queue_flat = q_cur_flat;
  assign valid_flat = v_q;
  assign count      = count_q;
  assign head_lvl   = q_q[0];
  assign head_valid = v_q[0];
  assign full       = (count_q == CNT_W'(DEPTH));
  assign rej_dup    = rej_dup_q;
  assign rej_full   = rej_full_q;
  assign rej_range  = rej_range_q;

endmodule

// File: tb/tb_lvl_request_queue.sv
// Bench for lvl_request_queue: two instances (4-deep/4 levels, 2-deep/3 levels)
// share stimulus and are each compared to a queue-based reference model.
module tb_lvl_request_queue;

  localparam int LW = 2;
  localparam int DA = 4, NA = 4;
  localparam int DB = 2, NB = 3;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic pressed_en = 1'b0;
  logic [LW-1:0] pressed_lvl = '0;
  logic pop_en = 1'b0;
`ifdef LVL_QUEUE_CANCEL_EN
  logic cancel_en = 1'b0;
  logic [LW-1:0] cancel_lvl = '0;
`endif

  logic [LW-1:0] head_lvl_a, head_lvl_b;
  logic head_valid_a, head_valid_b, full_a, full_b;
  logic [2:0] count_a;
  logic [1:0] count_b;
  logic [DA*LW-1:0] queue_flat_a;
  logic [DB*LW-1:0] queue_flat_b;
  logic [DA-1:0] valid_flat_a;
  logic [DB-1:0] valid_flat_b;
  logic rej_dup_a, rej_full_a, rej_range_a, rej_dup_b, rej_full_b, rej_range_b;

  int n_tests = 0;
  int n_fail = 0;
  int mq_a[$];
  int mq_b[$];
  int mr_a = 0;
  int mr_b = 0;

  always #5 clk = ~clk;

  lvl_request_queue #(.LVL_W(LW), .DEPTH(DA), .NUM_LVL(NA)) dut_a (
    .clk(clk), .rst_n(rst_n), .pressed_en(pressed_en), .pressed_lvl(pressed_lvl), .pop_en(pop_en),
`ifdef LVL_QUEUE_CANCEL_EN
    .cancel_en(cancel_en), .cancel_lvl(cancel_lvl),
`endif
    .head_lvl(head_lvl_a), .head_valid(head_valid_a), .count(count_a), .full(full_a),
    .queue_flat(queue_flat_a), .valid_flat(valid_flat_a),
    .rej_dup(rej_dup_a), .rej_full(rej_full_a), .rej_range(rej_range_a)
  );

  lvl_request_queue #(.LVL_W(LW), .DEPTH(DB), .NUM_LVL(NB)) dut_b (
    .clk(clk), .rst_n(rst_n), .pressed_en(pressed_en), .pressed_lvl(pressed_lvl), .pop_en(pop_en),
`ifdef LVL_QUEUE_CANCEL_EN
    .cancel_en(cancel_en), .cancel_lvl(cancel_lvl),
`endif
    .head_lvl(head_lvl_b), .head_valid(head_valid_b), .count(count_b), .full(full_b),
    .queue_flat(queue_flat_b), .valid_flat(valid_flat_b),
    .rej_dup(rej_dup_b), .rej_full(rej_full_b), .rej_range(rej_range_b)
  );

  task automatic check(input string name, input logic [31:0] act, input int exp);
    n_tests++;
    if (act !== 32'(exp)) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  // Reference: pop, then cancel, then push evaluated with range > dup > full priority.
  function automatic void mstep(input int qi[$], input int depth, input int nl,
                                output int qo[$], output int rej);
    int chk[$];
    int lvl;
    bit dup;
    lvl = int'(pressed_lvl);
    qo = qi;
    chk = qi;
    rej = 0;
    dup = 0;
    if (pop_en && qo.size() > 0) void'(qo.pop_front());
`ifdef LVL_QUEUE_CANCEL_EN
    if (cancel_en) begin
      int idx;
      idx = -1;
      for (int i = 0; i < qo.size(); i++) if (idx < 0 && qo[i] == int'(cancel_lvl)) idx = i;
      if (idx >= 0) qo.delete(idx);
    end
    chk = qo;
`endif
    if (pressed_en) begin
      foreach (chk[i]) if (chk[i] == lvl) dup = 1;
      if (lvl >= nl) rej = 1;
      else if (dup) rej = 2;
      else if (qo.size() >= depth) rej = 3;
      else qo.push_back(lvl);
    end
  endfunction

  function automatic int rej_bits(input int rej);
    case (rej)
      1: return 1;
      2: return 4;
      3: return 2;
      default: return 0;
    endcase
  endfunction

  task automatic cmp_one(input string tag, input int q[$], input int rej, input int depth,
                         input logic [31:0] cnt, input logic [31:0] qf, input logic [31:0] vf,
                         input logic hv, input logic [31:0] hl, input logic fl,
                         input logic rd, input logic rf, input logic rr);
    check({tag, " count"}, cnt, q.size());
    check({tag, " valid_flat"}, vf, (1 << q.size()) - 1);
    for (int i = 0; i < q.size(); i++)
      check($sformatf("%s entry%0d", tag, i), (qf >> (i * LW)) & 32'h3, q[i]);
    check({tag, " head_valid"}, 32'(hv), int'(q.size() > 0));
    if (q.size() > 0) check({tag, " head_lvl"}, hl, q[0]);
    check({tag, " full"}, 32'(fl), int'(q.size() == depth));
    check({tag, " rej"}, {29'b0, rd, rf, rr}, rej_bits(rej));
  endtask

  task automatic cmp_all();
    cmp_one("A", mq_a, mr_a, DA, 32'(count_a), 32'(queue_flat_a), 32'(valid_flat_a),
            head_valid_a, 32'(head_lvl_a), full_a, rej_dup_a, rej_full_a, rej_range_a);
    cmp_one("B", mq_b, mr_b, DB, 32'(count_b), 32'(queue_flat_b), 32'(valid_flat_b),
            head_valid_b, 32'(head_lvl_b), full_b, rej_dup_b, rej_full_b, rej_range_b);
  endtask

  task automatic step(input bit pe, input int lvl, input bit pp);
    int na[$];
    int nb[$];
    pressed_en = pe;
    pressed_lvl = LW'(lvl);
    pop_en = pp;
    mstep(mq_a, DA, NA, na, mr_a);
    mstep(mq_b, DB, NB, nb, mr_b);
    mq_a = na;
    mq_b = nb;
    @(posedge clk);
    #1;
    pressed_en = 1'b0;
    pop_en = 1'b0;
`ifdef LVL_QUEUE_CANCEL_EN
    cancel_en = 1'b0;
`endif
    cmp_all();
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    mq_a.delete();
    mq_b.delete();
    mr_a = 0;
    mr_b = 0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    #1;
    cmp_all();
  endtask

  typedef struct {
    bit pe;
    int lvl;
    bit pp;
    int cnt;
    int head;
    int rej;
  } vec_t;

  vec_t tbl[$];

  initial begin
    // Directed table for the 4-deep instance: rej 0 none, 1 range, 2 dup, 3 full; head -1 = empty.
    tbl.push_back('{1, 2, 0, 1, 2, 0});
    tbl.push_back('{1, 0, 0, 2, 2, 0});
    tbl.push_back('{1, 3, 0, 3, 2, 0});
    tbl.push_back('{1, 0, 0, 3, 2, 2});
    tbl.push_back('{0, 0, 1, 2, 0, 0});
    tbl.push_back('{0, 0, 1, 1, 3, 0});
    tbl.push_back('{1, 1, 1, 1, 1, 0});
    tbl.push_back('{1, 2, 0, 2, 1, 0});
    tbl.push_back('{1, 3, 0, 3, 1, 0});
    tbl.push_back('{1, 0, 0, 4, 1, 0});
    tbl.push_back('{1, 1, 0, 4, 1, 2});
    tbl.push_back('{0, 0, 1, 3, 2, 0});
    tbl.push_back('{0, 0, 1, 2, 3, 0});
    tbl.push_back('{0, 0, 1, 1, 0, 0});
    tbl.push_back('{0, 0, 1, 0, -1, 0});
    tbl.push_back('{0, 0, 1, 0, -1, 0});
    tbl.push_back('{0, 0, 1, 0, -1, 0});
    tbl.push_back('{0, 0, 1, 0, -1, 0});

    do_reset();
    check("reset count_a", 32'(count_a), 0);
    check("reset queue_flat_a", 32'(queue_flat_a), 0);

    foreach (tbl[k]) begin
      step(tbl[k].pe, tbl[k].lvl, tbl[k].pp);
      check($sformatf("tbl%0d count", k), 32'(count_a), tbl[k].cnt);
      check($sformatf("tbl%0d head_valid", k), 32'(head_valid_a), int'(tbl[k].head >= 0));
      if (tbl[k].head >= 0) check($sformatf("tbl%0d head", k), 32'(head_lvl_a), tbl[k].head);
      check($sformatf("tbl%0d rej", k), {29'b0, rej_dup_a, rej_full_a, rej_range_a},
            rej_bits(tbl[k].rej));
    end

    // Small instance: full, range and pop+push while full.
    do_reset();
    step(1, 0, 0);
    step(1, 1, 0);
    check("B full after 2", 32'(full_b), 1);
    step(1, 2, 0);
    check("B rej_full", 32'(rej_full_b), 1);
    check("B count held", 32'(count_b), 2);
    step(1, 3, 0);
    check("B rej_range", 32'(rej_range_b), 1);
    check("B rej_range only", {29'b0, rej_dup_b, rej_full_b, rej_range_b}, 1);
    step(0, 0, 0);
    check("B rej idle", {29'b0, rej_dup_b, rej_full_b, rej_range_b}, 0);
    step(1, 2, 1);
    check("B pop+push flat", 32'(queue_flat_b), 32'h9);
    check("B pop+push full", 32'(full_b), 1);

    do_reset();
    step(1, 0, 0);
    step(1, 1, 0);
    step(1, 0, 1);
`ifdef LVL_QUEUE_CANCEL_EN
    check("B pop+push popped head rej", 32'(rej_dup_b), 0);
    check("B pop+push popped head count", 32'(count_b), 2);
`else
    check("B pop+push popped head rej", 32'(rej_dup_b), 1);
    check("B pop+push popped head count", 32'(count_b), 1);
    check("B pop+push popped head head", 32'(head_lvl_b), 1);
`endif

    // Asynchronous reset mid-stream with a reject pulse live.
    do_reset();
    step(1, 1, 0);
    step(1, 2, 0);
    step(1, 3, 0);
    step(1, 2, 0);
    check("pre-reset count", 32'(count_a), 3);
    check("pre-reset rej_dup", 32'(rej_dup_a), 1);
    rst_n = 1'b0;
    mq_a.delete();
    mq_b.delete();
    mr_a = 0;
    mr_b = 0;
    #1;
    check("async count", 32'(count_a), 0);
    check("async valid_flat", 32'(valid_flat_a), 0);
    check("async queue_flat", 32'(queue_flat_a), 0);
    check("async head", {30'b0, head_valid_a, |head_lvl_a}, 0);
    check("async full/rej", {28'b0, full_a, rej_dup_a, rej_full_a, rej_range_a}, 0);
    @(negedge clk);
    rst_n = 1'b1;
    step(1, 2, 0);
    check("post-reset count", 32'(count_a), 1);
    check("post-reset head", 32'(head_lvl_a), 2);

`ifdef LVL_QUEUE_CANCEL_EN
    do_reset();
    step(1, 2, 0);
    step(1, 0, 0);
    step(1, 3, 0);
    cancel_en = 1'b1;
    cancel_lvl = 2'd0;
    step(0, 0, 0);
    check("cancel mid count", 32'(count_a), 2);
    check("cancel mid flat", 32'(queue_flat_a) & 32'hF, 32'hE);
    cancel_en = 1'b1;
    cancel_lvl = 2'd2;
    step(1, 2, 1);
    check("cancel+pop+push flat", 32'(queue_flat_a) & 32'hF, 32'hB);
    check("cancel+pop+push count", 32'(count_a), 2);
    cancel_en = 1'b1;
    cancel_lvl = 2'd3;
    step(0, 0, 1);
    check("cancel head with pop", 32'(count_a), 1);
`endif

    do_reset();
    for (int n = 0; n < 3000; n++) begin
`ifdef LVL_QUEUE_CANCEL_EN
      cancel_en = ($urandom_range(0, 9) < 2);
      cancel_lvl = LW'($urandom_range(0, 3));
`endif
      step($urandom_range(0, 9) < 6, int'($urandom_range(0, 3)), $urandom_range(0, 9) < 3);
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
